// File: rtl/scan_sel_gen.sv
// Scan select generator: steps a 2-to-4 decoder through the enabled channels,
// with a blanking gap (G=1) before each ON slot (G=0).
module scan_sel_gen #(
    parameter int unsigned DIV       = 4,
    parameter int unsigned BLANK_CYC = 1
) (
    input  logic       CLK,
    input  logic       RST_L,
    input  logic       EN,
    input  logic [3:0] MASK,
    output logic       A,
    output logic       B,
    output logic       G,
    output logic       FRAME,
    output logic       ACTIVE
);

    // Dwell counter covers DIV up to 255, blank counter covers BLANK_CYC up to 15.
    localparam int unsigned DWELL_W = 8;
    localparam int unsigned BLANK_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    state_t               state;
    logic [1:0]           sel;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic [BLANK_W-1:0]   blank_cnt;
    logic [1:0]           first_sel_c;
    logic [1:0]           next_sel_c;
    logic                 run_c;

    // Lowest-index enabled channel.
    function automatic logic [1:0] first_ch(input logic [3:0] m);
        logic [1:0] res;
        logic       found;
        res   = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && m[i]) begin
                res   = 2'(i);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Next enabled channel after cur, wrapping round to cur itself last.
    function automatic logic [1:0] next_ch(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] res;
        logic [1:0] cand;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = cur + 2'(k);
            if (!found && m[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign first_sel_c = first_ch(MASK);
    assign next_sel_c  = next_ch(sel, MASK);
    assign run_c       = EN && (MASK != 4'd0);

    // Select bits come straight from the channel register.
    assign A = sel[0];
    assign B = sel[1];

    // Scan state machine with registered G, FRAME and ACTIVE.
    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            state     <= ST_IDLE;
            sel       <= 2'd0;
            dwell_cnt <= '0;
            blank_cnt <= '0;
            G         <= 1'b1;
            FRAME     <= 1'b0;
            ACTIVE    <= 1'b0;
        end else begin
            FRAME <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (run_c) begin
                        state     <= ST_BLANK;
                        sel       <= first_sel_c;
                        blank_cnt <= '0;
                        dwell_cnt <= '0;
                        G         <= 1'b1;
                        ACTIVE    <= 1'b1;
                    end
                end
                ST_BLANK: begin
                    if (!run_c) begin
                        state     <= ST_IDLE;
                        blank_cnt <= '0;
                        dwell_cnt <= '0;
                        G         <= 1'b1;
                        ACTIVE    <= 1'b0;
                    end else if (!MASK[sel]) begin
                        // Channel withdrawn while blanking: move on and blank afresh.
                        sel       <= next_sel_c;
                        blank_cnt <= '0;
                    end else if (blank_cnt == BLANK_W'(BLANK_CYC - 1)) begin
                        state     <= ST_ON;
                        blank_cnt <= '0;
                        dwell_cnt <= '0;
                        G         <= 1'b0;
                    end else begin
                        blank_cnt <= blank_cnt + BLANK_W'(1);
                    end
                end
                ST_ON: begin
                    if (!run_c) begin
                        state     <= ST_IDLE;
                        blank_cnt <= '0;
                        dwell_cnt <= '0;
                        G         <= 1'b1;
                        ACTIVE    <= 1'b0;
                    end else if (!MASK[sel] || (dwell_cnt == DWELL_W'(DIV - 1))) begin
                        // Advance; a non-increasing index means the scan wrapped.
                        state     <= ST_BLANK;
                        sel       <= next_sel_c;
                        FRAME     <= (next_sel_c <= sel);
                        blank_cnt <= '0;
                        dwell_cnt <= '0;
                        G         <= 1'b1;
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    blank_cnt <= '0;
                    dwell_cnt <= '0;
                    G         <= 1'b1;
                    ACTIVE    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Bench for scan_sel_gen: slot-position reference model plus directed checks.
module tb_scan_sel_gen;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int SLOT  = DIV + BLANK;

    logic       CLK = 1'b0;
    logic       RST_L;
    logic       EN;
    logic [3:0] MASK;
    logic       A, B, G, FRAME, ACTIVE;

    int tests = 0;
    int fails = 0;

    // Reference state: scanning flag, channel number, position within slot.
    bit m_act;
    int m_ch;
    int m_pos;
    bit m_frame;
    int m_n;

    scan_sel_gen #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .CLK   (CLK),
        .RST_L (RST_L),
        .EN    (EN),
        .MASK  (MASK),
        .A     (A),
        .B     (B),
        .G     (G),
        .FRAME (FRAME),
        .ACTIVE(ACTIVE)
    );

    always #5 CLK = ~CLK;

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int after(input int c, input logic [3:0] m);
        for (int k = 1; k <= 4; k++) if (m[(c + k) % 4]) return (c + k) % 4;
        return c;
    endfunction

    // Slot model: positions 0..BLANK-1 are blanking, BLANK..SLOT-1 are ON.
    always @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            m_act = 0; m_ch = 0; m_pos = 0; m_frame = 0;
        end else begin
            m_frame = 0;
            if (!m_act) begin
                if (EN && MASK != 0) begin
                    m_act = 1; m_ch = lowest(MASK); m_pos = 0;
                end
            end else if (!EN || MASK == 0) begin
                m_act = 0; m_pos = 0;
            end else if (!MASK[m_ch] || m_pos == SLOT - 1) begin
                m_n = after(m_ch, MASK);
                if (m_pos >= BLANK) m_frame = (m_n <= m_ch);
                m_ch = m_n; m_pos = 0;
            end else begin
                m_pos = m_pos + 1;
            end
        end
    end

    // Expected {A,B,G,FRAME,ACTIVE}.
    function automatic logic [4:0] expv();
        return {m_ch[0], m_ch[1], !(m_act && m_pos >= BLANK), m_frame, m_act};
    endfunction

    task automatic tick(input logic en, input logic [3:0] mask);
        EN = en;
        MASK = mask;
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic go_idle();
        tick(1'b0, 4'hF);
        tick(1'b0, 4'hF);
    endtask

    task automatic test_reset();
        RST_L = 1'b0; EN = 1'b0; MASK = 4'h0;
        repeat (2) @(negedge CLK);
        tests++;
        if ({A, B, G, FRAME, ACTIVE} !== 5'b00100) begin
            fails++;
            $display("FAIL reset_state got=%b exp=00100", {A, B, G, FRAME, ACTIVE});
        end
        RST_L = 1'b1;
        tick(1'b0, 4'h0);
        tests++;
        if ({A, B, G, FRAME, ACTIVE} !== 5'b00100) begin
            fails++;
            $display("FAIL idle_after_release got=%b exp=00100", {A, B, G, FRAME, ACTIVE});
        end
    endtask

    task automatic test_full_scan();
        int last = -1;
        for (int i = 0; i < 65; i++) begin
            tick(1'b1, 4'hF);
            tests++;
            if ({A, B, G, FRAME, ACTIVE} !== expv()) begin
                fails++;
                $display("FAIL full_scan cyc=%0d got=%b exp=%b", i, {A, B, G, FRAME, ACTIVE}, expv());
            end
            if (i == 0) begin
                tests++;
                if (ACTIVE !== 1'b1 || G !== 1'b1 || {B, A} !== 2'b00) begin
                    fails++;
                    $display("FAIL full_scan_entry got ACTIVE=%b G=%b BA=%b exp 1 1 00", ACTIVE, G, {B, A});
                end
            end
            if (i == BLANK) begin
                tests++;
                if (G !== 1'b0) begin
                    fails++;
                    $display("FAIL full_scan_latency got G=%b exp 0", G);
                end
            end
            if (FRAME === 1'b1) begin
                if (last >= 0) begin
                    tests++;
                    if (i - last != 4 * SLOT) begin
                        fails++;
                        $display("FAIL full_scan_period got=%0d exp=%0d", i - last, 4 * SLOT);
                    end
                end
                last = i;
            end
        end
        tests++;
        if (last != 60) begin
            fails++;
            $display("FAIL full_scan_last_frame got=%0d exp=60", last);
        end
        go_idle();
    endtask

    task automatic test_two_channels();
        int last = -1;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 4'b0101);
            tests++;
            if ({A, B, G, FRAME, ACTIVE} !== expv()) begin
                fails++;
                $display("FAIL two_ch cyc=%0d got=%b exp=%b", i, {A, B, G, FRAME, ACTIVE}, expv());
            end
            if (FRAME === 1'b1) begin
                tests++;
                if ({B, A} !== 2'b00 || (last >= 0 && i - last != 2 * SLOT)) begin
                    fails++;
                    $display("FAIL two_ch_frame cyc=%0d got BA=%b gap=%0d exp BA=00 gap=%0d", i, {B, A}, i - last, 2 * SLOT);
                end
                last = i;
            end
        end
        go_idle();
    endtask

    task automatic test_single_channel();
        int gz = 0;
        int frames = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1'b1, 4'b0100);
            tests++;
            if ({A, B, G, FRAME, ACTIVE} !== expv() || {B, A} !== 2'b10) begin
                fails++;
                $display("FAIL single_ch cyc=%0d got=%b exp=%b", i, {A, B, G, FRAME, ACTIVE}, expv());
            end
            if (G === 1'b0) gz++;
            if (FRAME === 1'b1) frames++;
        end
        tests++;
        if (gz != 24 || frames != 5) begin
            fails++;
            $display("FAIL single_ch_counts got G0=%0d frames=%0d exp G0=24 frames=5", gz, frames);
        end
        go_idle();
    endtask

    task automatic test_en_drop();
        for (int i = 0; i < 8; i++) tick(1'b1, 4'hF);
        tests++;
        if (G !== 1'b0 || {B, A} !== 2'b01) begin
            fails++;
            $display("FAIL en_drop_pre got G=%b BA=%b exp 0 01", G, {B, A});
        end
        tick(1'b0, 4'hF);
        tests++;
        if (G !== 1'b1 || ACTIVE !== 1'b0 || FRAME !== 1'b0) begin
            fails++;
            $display("FAIL en_drop got G=%b ACTIVE=%b FRAME=%b exp 1 0 0", G, ACTIVE, FRAME);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 4'hF);
            tests++;
            if ({A, B, G, FRAME, ACTIVE} !== expv()) begin
                fails++;
                $display("FAIL en_restart cyc=%0d got=%b exp=%b", i, {A, B, G, FRAME, ACTIVE}, expv());
            end
            if (i == 0 || i == 4) begin
                tests++;
                if ({B, A} !== 2'b00 || G !== (i == 0 ? 1'b1 : 1'b0)) begin
                    fails++;
                    $display("FAIL en_restart_ch cyc=%0d got BA=%b G=%b", i, {B, A}, G);
                end
            end
        end
        go_idle();
    endtask

    task automatic test_mask_change();
        for (int i = 0; i < 7; i++) tick(1'b1, 4'hF);
        tick(1'b1, 4'b1101);
        tests++;
        if ({B, A} !== 2'b10 || G !== 1'b1 || FRAME !== 1'b0 || ACTIVE !== 1'b1) begin
            fails++;
            $display("FAIL mask_change got BA=%b G=%b FRAME=%b exp 10 1 0", {B, A}, G, FRAME);
        end
        tests++;
        if ({A, B, G, FRAME, ACTIVE} !== expv()) begin
            fails++;
            $display("FAIL mask_change_model got=%b exp=%b", {A, B, G, FRAME, ACTIVE}, expv());
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 18; i++) tick(1'b1, 4'hF);
        tests++;
        if (G !== 1'b0 || {B, A} !== 2'b11) begin
            fails++;
            $display("FAIL async_pre got G=%b BA=%b exp 0 11", G, {B, A});
        end
        #2 RST_L = 1'b0;
        #1;
        tests++;
        if (G !== 1'b1 || A !== 1'b0 || B !== 1'b0 || ACTIVE !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got G=%b A=%b B=%b ACTIVE=%b exp 1 0 0 0", G, A, B, ACTIVE);
        end
        @(negedge CLK);
        RST_L = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick(1'b1, 4'hF);
            tests++;
            if ({A, B, G, FRAME, ACTIVE} !== expv() || (i == 0 && {B, A} !== 2'b00)) begin
                fails++;
                $display("FAIL async_resume cyc=%0d got=%b exp=%b", i, {A, B, G, FRAME, ACTIVE}, expv());
            end
        end
        go_idle();
    endtask

    task automatic test_random();
        logic [3:0] mask = 4'hF;
        logic       en;
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(15) != 0);
            if ($urandom_range(7) == 0) mask = 4'($urandom_range(15));
            tick(en, mask);
            tests++;
            if ({A, B, G, FRAME, ACTIVE} !== expv()) begin
                fails++;
                $display("FAIL random cyc=%0d en=%b mask=%b got=%b exp=%b", i, en, mask, {A, B, G, FRAME, ACTIVE}, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_two_channels();
        test_single_channel();
        test_en_drop();
        test_mask_change();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scan_sel_gen.md
SCAN_SEL_GEN -- requirements
Module: scan_sel_gen

Interface
REQ-001 Parameter DIV, default 4, meaning clock cycles per channel ON slot; legal range 2..255.
REQ-002 Parameter BLANK_CYC, default 1, meaning blanking cycles between ON slots; legal range 1..15.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST_L  input  1  reset; asynchronous assertion, active-low.
REQ-005 EN  input  1  scan enable, active-high, sampled on CLK.
REQ-006 MASK  input  4  per-channel enable; bit i=1 includes channel i in the scan.
REQ-007 A  output  1  channel select LSB, driven to the 2-to-4 decoder A input.
REQ-008 B  output  1  channel select MSB, driven to the 2-to-4 decoder B input.
REQ-009 G  output  1  active-low decoder enable; 0 only in ON state.
REQ-010 FRAME  output  1  one-cycle pulse marking scan wrap-around.
REQ-011 ACTIVE  output  1  high whenever state is not IDLE.
REQ-012 All outputs SHALL be registered; no combinational path from inputs to outputs.

Function
REQ-013 State machine SHALL have exactly three states: IDLE, BLANK, ON.
REQ-014 IDLE: G=1, {B,A} held; exit to BLANK when EN=1 and MASK!=0, loading {B,A} with lowest-index set MASK bit.
REQ-015 BLANK: G=1, {B,A} stable; SHALL last exactly BLANK_CYC cycles, then go to ON.
REQ-016 ON: G=0; SHALL last exactly DIV cycles, then go to BLANK with {B,A} advanced to next enabled channel.
REQ-017 Next enabled channel SHALL be first set MASK bit searching sel+1, sel+2, sel+3, sel (mod 4); single enabled channel re-selects itself.
REQ-018 {B,A} SHALL change only on entry to BLANK, never during BLANK or ON.
REQ-019 FRAME SHALL pulse high for one cycle, coincident with BLANK entry from ON, when new channel index <= old index (wrap); otherwise 0.
REQ-020 EN=0 or MASK=0 sampled in BLANK or ON: next state IDLE, G=1 next cycle, dwell and blank counters cleared, FRAME=0.
REQ-021 Current channel's MASK bit cleared while in ON: next cycle enter BLANK with next enabled channel (REQ-017); FRAME per REQ-019.
REQ-022 Current channel's MASK bit cleared while in BLANK: re-select next enabled channel on that edge and restart BLANK count.
REQ-023 MASK changes affecting only other channels SHALL take effect at the next advance.
REQ-024 Latency: EN rise sampled at edge k -> ACTIVE=1 after edge k, G=0 after edge k+BLANK_CYC.
REQ-025 Steady full scan period SHALL be 4*(DIV+BLANK_CYC) cycles; per channel DIV+BLANK_CYC.
REQ-026 Dwell and blank counters SHALL be sized for max parameter value without overflow.

Reset
REQ-027 RST_L=0 SHALL asynchronously force state IDLE, A=0, B=0, G=1, FRAME=0, ACTIVE=0, all counters 0.
REQ-028 Reset asserted mid-ON SHALL drive G=1 without waiting for a clock edge.
REQ-029 After RST_L release, first state change SHALL occur no earlier than the first rising CLK edge that samples RST_L=1.

Verification
REQ-030 Reset, DIV=4, BLANK_CYC=1, EN=1, MASK=1111 -> {B,A}=00 BLANK 1 cycle, G=0 4 cycles, then {B,A}=01,10,11 likewise; FRAME pulses on return to 00 every 20 cycles.
REQ-031 MASK=0101, same params -> sequence 00,10,00,10; FRAME on each entry to 00; period 10 cycles.
REQ-032 MASK=0100 -> {B,A}=10 constant, G pattern 1,0,0,0,0 repeating, FRAME every 5 cycles.
REQ-033 EN dropped in 2nd ON cycle of channel 01 -> G=1 next cycle, ACTIVE=0; EN re-raised -> restart at channel 00 with full BLANK then full DIV.
REQ-034 MASK 1111->1101 during ON of channel 01 -> next cycle BLANK with {B,A}=10, no FRAME.
REQ-035 RST_L pulsed low between clock edges during ON of channel 11 -> G=1, A=B=0 immediately; normal scan from 00 after release.
